pdm_mic_rcv: RTL and testbench

Stereo PDM microphone receiver; the capture-side counterpart of the speaker PDM drivers. Generates the microphone bit clock and samples a shared PDM data line: left channel on one mic_clk phase, right channel on the other. Decimates each 1-bit stream with a 3rd-order CIC filter. Presents signed 16-bit left/right PCM samples with a single-cycle vld, matching the channel/vld format the EQ engine consumes.

---
 rtl/pdm_pkg.sv | 29 ++
 rtl/cic_decim.sv | 111 +++++++++++
 rtl/pdm_mic_rcv.sv | 97 +++++++++
 tb/tb_pdm_mic_rcv.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// +--------------------------------------------------------------------------+
// | pdm_pkg : shared constants, sample type and helpers for PDM audio blocks |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pdm_pkg;

    localparam int CIC_ORDER      = 3;
    localparam int WARMUP_SAMPLES = 3;

    typedef logic signed [15:0] sample_t;

    function automatic int cic_width(input int dec);
        return CIC_ORDER * $clog2(dec) + 1;
    endfunction

    function automatic sample_t sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_decim.sv
// +--------------------------------------------------------------------------+
// | cic_decim : 3rd-order CIC decimator for one 1-bit PDM stream, with       |
// | offset removal, scaling and saturation. Optional DC blocker: HPF_EN.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cic_decim
    import pdm_pkg::*;
#(
    parameter int DEC_RATIO = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_bit,
    input  logic    i_bit_en,
    input  logic    i_dec_stb,
    output sample_t o_sample,
    output logic    o_valid
);

    localparam int W = cic_width(DEC_RATIO);
    // Mid-scale (density 0.5) sits at 2^(W-2); full scale maps to +/-2^15.
    localparam logic signed [31:0] c_OFFSET = 32'sd1 <<< (W - 2);

    logic [W-1:0]       r_int1, r_int2, r_int3;
    logic [W-1:0]       r_d1, r_d2, r_d3;
    logic [W-1:0]       r_c1, r_c2, r_c3;
    logic [2:0]         r_stg;
    logic signed [31:0] w_off, w_scl;
    sample_t            w_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int1 <= '0; r_int2 <= '0; r_int3 <= '0;
            r_d1   <= '0; r_d2   <= '0; r_d3   <= '0;
            r_c1   <= '0; r_c2   <= '0; r_c3   <= '0;
            r_stg  <= '0;
        end else begin
            if (i_bit_en) begin
                r_int1 <= r_int1 + {{(W-1){1'b0}}, i_bit};
                r_int2 <= r_int2 + r_int1;
                r_int3 <= r_int3 + r_int2;
            end
            r_stg <= {r_stg[1:0], i_dec_stb};
            // One comb stage per clk after the decimation strobe.
            if (i_dec_stb) begin
                r_c1 <= r_int3 - r_d1;
                r_d1 <= r_int3;
            end
            if (r_stg[0]) begin
                r_c2 <= r_c1 - r_d2;
                r_d2 <= r_c1;
            end
            if (r_stg[1]) begin
                r_c3 <= r_c2 - r_d3;
                r_d3 <= r_c2;
            end
        end
    end

    assign w_off = $signed(32'(r_c3)) - c_OFFSET;

    generate
        if (W >= 17) begin : g_shr
            assign w_scl = w_off >>> (W - 17);
        end else begin : g_shl
            assign w_scl = w_off <<< (17 - W);
        end
    endgenerate

    assign w_x = sat16(w_scl);

`ifdef HPF_EN
    logic signed [31:0] w_hpf;
    logic signed [17:0] w_y18;
    logic signed [17:0] r_y_prev;
    sample_t            r_x_prev;
    sample_t            r_out;
    logic               r_vld;

    assign w_hpf = 32'(w_x) - 32'(r_x_prev) + 32'(r_y_prev) - 32'(r_y_prev >>> 8);
    assign w_y18 = (w_hpf > 32'sd131071)  ? 18'sh1FFFF :
                   (w_hpf < -32'sd131072) ? 18'sh20000 : w_hpf[17:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_prev <= '0;
            r_y_prev <= '0;
            r_out    <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_vld <= r_stg[2];
            if (r_stg[2]) begin
                r_x_prev <= w_x;
                r_y_prev <= w_y18;
                r_out    <= sat16(w_hpf);
            end
        end
    end

    assign o_sample = r_out;
    assign o_valid  = r_vld;
`else
    assign o_sample = w_x;
    assign o_valid  = r_stg[2];
`endif

endmodule

`default_nettype wire

// File: rtl/pdm_mic_rcv.sv
// +--------------------------------------------------------------------------+
// | pdm_mic_rcv : stereo PDM microphone receiver (clock gen, capture, CIC,   |
// | warm-up gating). Optional DC blocker via macro HPF_EN.  Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module pdm_mic_rcv
    import pdm_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DEC_RATIO = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    output logic    mic_clk,
    input  logic    mic_data,
    output sample_t lft_chnnl,
    output sample_t rght_chnnl,
    output logic    vld
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = $clog2(DEC_RATIO);
    localparam logic [CW-1:0] c_HALF    = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] c_HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] c_LAST    = CW'(CLK_DIV - 1);
    localparam logic [1:0]    c_WARM    = 2'(WARMUP_SAMPLES);

    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_per;
    logic [1:0]    r_sync;
    logic [1:0]    r_warm;
    logic          r_dec_stb;
    logic          w_cap_l, w_cap_r;
    sample_t       w_l_smp, w_r_smp;
    logic          w_l_vld, w_r_vld;

    assign w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    // Synchronizer output at these counts reflects the pin two clocks earlier,
    // still well inside the phase driven by the respective microphone.
    assign w_cap_r = (r_cnt == c_HALF_M1);
    assign w_cap_l = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            mic_clk    <= 1'b0;
            r_sync     <= '0;
            r_per      <= '0;
            r_dec_stb  <= 1'b0;
            r_warm     <= '0;
            lft_chnnl  <= '0;
            rght_chnnl <= '0;
            vld        <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            mic_clk   <= (w_cnt_nxt >= c_HALF);
            r_sync    <= {r_sync[0], mic_data};
            r_dec_stb <= w_cap_l && (r_per == '1);
            if (w_cap_l)
                r_per <= r_per + 1'b1;
            vld <= 1'b0;
            if (w_l_vld && w_r_vld) begin
                if (r_warm == c_WARM) begin
                    lft_chnnl  <= w_l_smp;
                    rght_chnnl <= w_r_smp;
                    vld        <= 1'b1;
                end else begin
                    r_warm <= r_warm + 1'b1;
                end
            end
        end
    end

    cic_decim #(.DEC_RATIO(DEC_RATIO)) u_cic_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit     (r_sync[1]),
        .i_bit_en  (w_cap_l),
        .i_dec_stb (r_dec_stb),
        .o_sample  (w_l_smp),
        .o_valid   (w_l_vld)
    );

    cic_decim #(.DEC_RATIO(DEC_RATIO)) u_cic_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit     (r_sync[1]),
        .i_bit_en  (w_cap_r),
        .i_dec_stb (r_dec_stb),
        .o_sample  (w_r_smp),
        .o_valid   (w_r_vld)
    );

endmodule

`default_nettype wire

// File: tb/tb_pdm_mic_rcv.sv
// +--------------------------------------------------------------------------+
// | tb_pdm_mic_rcv : directed self-checking bench for pdm_mic_rcv            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pdm_mic_rcv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mic_clk;
    logic        mic_data;
    logic [15:0] lft_chnnl;
    logic [15:0] rght_chnnl;
    logic        vld;

    int n_chk = 0;
    int n_err = 0;
    int mode  = 0;
    int per_cnt = 0;
    logic lb, rb;

    pdm_mic_rcv #(.CLK_DIV(16), .DEC_RATIO(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mic_clk    (mic_clk),
        .mic_data   (mic_data),
        .lft_chnnl  (lft_chnnl),
        .rght_chnnl (rght_chnnl),
        .vld        (vld)
    );

    always #5 clk = ~clk;

    // Each mic drives the line during its own phase: right while mic_clk low.
    always @(negedge mic_clk) per_cnt++;

    always_comb begin
        lb = 1'b0;
        rb = 1'b0;
        case (mode)
            1: begin lb = 1'b1;       rb = 1'b1;       end
            2: begin lb = per_cnt[0]; rb = per_cnt[0]; end
            3: begin lb = 1'b1;       rb = 1'b0;       end
            default: begin lb = 1'b0; rb = 1'b0;      end
        endcase
        mic_data = mic_clk ? lb : rb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_vld(input int bound, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            cyc++;
            if (vld) ok = 1'b1;
        end
    endtask

    task automatic run_mode(input int m, input logic [15:0] el, input logic [15:0] er,
                            input string nm);
        int   cyc;
        logic ok;
        mode = m;
        do_reset();
        wait_vld(5000, cyc, ok);
        check({nm, "_first_vld"}, 32'(ok), 32'd1);
        check({nm, "_warmup"}, 32'(cyc > 3072 && cyc < 4200), 32'd1);
        check({nm, "_lft1"}, 32'(lft_chnnl), 32'(el));
        check({nm, "_rght1"}, 32'(rght_chnnl), 32'(er));
        wait_vld(1100, cyc, ok);
        check({nm, "_period"}, 32'(cyc), 32'd1024);
        check({nm, "_lft2"}, 32'(lft_chnnl), 32'(el));
        check({nm, "_rght2"}, 32'(rght_chnnl), 32'(er));
    endtask

    initial begin
        int   cnt;
        int   cyc;
        logic ok;
        logic seen;

        // Reset state and mic_clk timing.
        repeat (3) @(negedge clk);
        check("rst_mic_clk", 32'(mic_clk), 32'd0);
        check("rst_lft", 32'(lft_chnnl), 32'd0);
        check("rst_rght", 32'(rght_chnnl), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        while (cnt < 40 && mic_clk !== 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        check("mic_clk_first_rise", 32'(cnt), 32'd8);
        cnt = 0;
        while (cnt < 40 && mic_clk === 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        check("mic_clk_high_len", 32'(cnt), 32'd8);

        run_mode(1, 16'h7FFF, 16'h7FFF, "full");
        run_mode(0, 16'h8000, 16'h8000, "zero");
        run_mode(2, 16'h0000, 16'h0000, "idle");
        run_mode(3, 16'h7FFF, 16'h8000, "sep");
        run_mode(1, 16'h7FFF, 16'h7FFF, "full_b");

        // Reset between the next decimation strobe and its vld.
        repeat (1021) @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (vld) seen = 1'b1;
        end
        check("midrst_no_vld", 32'(seen), 32'd0);
        check("midrst_lft", 32'(lft_chnnl), 32'd0);
        check("midrst_rght", 32'(rght_chnnl), 32'd0);
        rst_n = 1'b1;
        wait_vld(3072, cyc, ok);
        check("midrst_warmup_repeat", 32'(ok), 32'd0);
        check("midrst_lft_held", 32'(lft_chnnl), 32'd0);
        wait_vld(2000, cyc, ok);
        check("midrst_first_vld", 32'(ok), 32'd1);
        check("midrst_lft_after", 32'(lft_chnnl), 32'h7FFF);
        check("midrst_rght_after", 32'(rght_chnnl), 32'h7FFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
